// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery constant generator: default widths and FSM encoding.
// The CALC_N state exists only when MONT_NPRIME_EN is defined.
package mont_pkg;

  localparam int W_DEF    = 1024;
  localparam int WORD_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC_R = 2'd1;
  localparam logic [1:0] ST_CALC_T = 2'd2;
  localparam logic [1:0] ST_CALC_N = 2'd3;

  typedef enum logic [1:0] {
`ifdef MONT_NPRIME_EN
    CALC_N = ST_CALC_N,
`endif
    IDLE   = ST_IDLE,
    CALC_R = ST_CALC_R,
    CALC_T = ST_CALC_T
  } mont_state_e;

endpackage

// File: rtl/mont_dbl_reduce.sv
// One modular doubling step: x' = 2x mod M, assuming x < M on entry.
module mont_dbl_reduce
  import mont_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   x,
  input  logic [W-1:0] M,
  output logic [W:0]   x_next
);

  logic [W:0] dbl;
  logic [W:0] m_ext;

  // x < M < 2^W, so 2x fits in W+1 bits and the top bit shifted out is always 0.
  always_comb begin
    dbl    = x << 1;
    m_ext  = {1'b0, M};
    x_next = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
  end

endmodule

// File: rtl/mont_const_gen.sv
// Computes R mod M and R^2 mod M (R = 2^W) by repeated modular doubling.
// Define MONT_NPRIME_EN to also compute N_p = -M^-1 mod 2^WORD.
module mont_const_gen
  import mont_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int WORD = WORD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    M_r,
  output logic [W-1:0]    R_r,
  output logic [W-1:0]    R_t,
`ifdef MONT_NPRIME_EN
  output logic [WORD-1:0] N_p,
`endif
  output logic            busy,
  output logic            done,
  output logic            err,
  output mont_state_e     dbg_state
);

  // Handshake: start is a one-cycle request taken only when idle and not busy;
  // done pulses for one cycle with results (and err) held until the next accepted start.

  localparam int CW = $clog2(W + 1);

  mont_state_e    state, state_nxt;
  logic [W-1:0]   m_q;
  logic [W:0]     x;
  logic [W:0]     x_step;
  logic [CW-1:0]  cnt;
  logic           rej_pend;
  logic           accept;
  logic           m_valid;
  logic           last_step;

  mont_dbl_reduce #(.W(W)) u_dbl_reduce (
    .x      (x),
    .M      (m_q),
    .x_next (x_step)
  );

`ifdef MONT_NPRIME_EN
  logic [WORD:0]   a, a_sum, a_next;
  logic [WORD-1:0] q, q_next;
  logic            last_n;

  // Bit-serial Hensel lifting: each step fixes one bit of q so that M*q == -1 mod 2^(i+1).
  always_comb begin
    a_sum  = a + (a[0] ? {1'b0, m_q[WORD-1:0]} : '0);
    a_next = a_sum >> 1;
    q_next = {a[0], q[WORD-1:1]};
    last_n = (cnt == CW'(WORD - 1));
  end
`endif

  assign dbg_state = state;
  assign m_valid   = M_r[0] && (M_r != W'(1));
  assign accept    = start && (state == IDLE) && !busy;
  assign last_step = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept && m_valid) state_nxt = CALC_R;
      CALC_R: if (last_step) state_nxt = CALC_T;
`ifdef MONT_NPRIME_EN
      CALC_T: if (last_step) state_nxt = CALC_N;
      CALC_N: if (last_n) state_nxt = IDLE;
`else
      CALC_T: if (last_step) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q      <= '0;
      x        <= '0;
      cnt      <= '0;
      rej_pend <= 1'b0;
      R_r      <= '0;
      R_t      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef MONT_NPRIME_EN
      a        <= '0;
      q        <= '0;
      N_p      <= '0;
`endif
    end else begin
      done <= 1'b0;
      // A rejected modulus never leaves IDLE; it reports one cycle after acceptance.
      if (rej_pend) begin
        rej_pend <= 1'b0;
        done     <= 1'b1;
        err      <= 1'b1;
        busy     <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            m_q  <= M_r;
            R_r  <= '0;
            R_t  <= '0;
            err  <= 1'b0;
            busy <= 1'b1;
            cnt  <= '0;
`ifdef MONT_NPRIME_EN
            N_p  <= '0;
`endif
            if (m_valid) x <= W'(1);
            else         rej_pend <= 1'b1;
          end
        end
        CALC_R: begin
          x   <= x_step;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            R_r <= x_step[W-1:0];
            cnt <= '0;
          end
        end
        CALC_T: begin
          x   <= x_step;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            R_t <= x_step[W-1:0];
            cnt <= '0;
`ifdef MONT_NPRIME_EN
            a   <= (WORD + 1)'(1);
            q   <= '0;
`else
            done <= 1'b1;
            busy <= 1'b0;
`endif
          end
        end
`ifdef MONT_NPRIME_EN
        CALC_N: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (last_n) begin
            N_p  <= q_next;
            cnt  <= '0;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
